// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with BOOT/RUN/TRAP control.
// Optional macro PC_MISALIGN_TRAP_EN traps on redirect targets with bits [1:0] != 0.
`ifndef INSTRUCTION_MEMORY_ADDRESS_WIDTH
`define INSTRUCTION_MEMORY_ADDRESS_WIDTH 32
`endif
`ifndef RISC_V_DATA_WIDTH
`define RISC_V_DATA_WIDTH 32
`endif

module pc_sequencer #(
  parameter int ADDR_WIDTH = `INSTRUCTION_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = `RISC_V_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ALU_zero_flag,
  input  logic                  ctrl_branch,
  input  logic                  ctrl_jump,
  input  logic                  ctrl_jalr,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] jalr_base,
  input  logic                  stall,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic                  pc_valid,
  output logic [ADDR_WIDTH-1:0] link_address,
  output logic                  trap
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] offset_ext;
  logic [ADDR_WIDTH-1:0] jalr_target;
  logic [ADDR_WIDTH-1:0] rel_target;
  logic [ADDR_WIDTH-1:0] seq_target;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  redirect;
  logic                  advance;

  assign jalr_sum = jalr_base + offset;

  // Offset is sign-extended into the PC width; the JALR sum is truncated or zero-extended.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_narrow_pc
      assign offset_ext  = offset[ADDR_WIDTH-1:0];
      assign jalr_target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    end else begin : g_wide_pc
      assign offset_ext  = {{(ADDR_WIDTH-DATA_WIDTH){offset[DATA_WIDTH-1]}}, offset};
      assign jalr_target = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, jalr_sum[DATA_WIDTH-1:1], 1'b0};
    end
  endgenerate

  assign rel_target   = instruction_address + offset_ext;
  assign seq_target   = instruction_address + ADDR_WIDTH'(STEP);
  assign link_address = seq_target;
  assign advance      = (state == RUN) && !stall && out_ready;
  assign redirect     = ctrl_jalr || ctrl_jump || (ctrl_branch && ALU_zero_flag);

  always_comb begin
    redirect_target = rel_target;
    if (ctrl_jalr) redirect_target = jalr_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= BOOT;
      instruction_address <= RESET_VECTOR;
      pc_valid            <= 1'b0;
      trap                <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (advance) begin
            if (!redirect) begin
              instruction_address <= seq_target;
            end else begin
`ifdef PC_MISALIGN_TRAP_EN
              if (redirect_target[1:0] != 2'b00) begin
                state    <= TRAP;
                pc_valid <= 1'b0;
                trap     <= 1'b1;
              end else begin
                instruction_address <= redirect_target;
              end
`else
              instruction_address <= {redirect_target[ADDR_WIDTH-1:2], 2'b00};
`endif
            end
          end
        end
        TRAP: begin
          pc_valid <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
          trap     <= 1'b0;
        end
      endcase
    end
  end

endmodule
